// File: rtl/dfp96_norm_seq.sv
// Sequential BCD significand normaliser for unpacked DFP96 values.
// The FSM shifts the significand left by one digit per enabled clock. It stops when the
// MSD is non-zero, the significand is zero, the value is inf/NaN, or the exponent reaches 0.
//
// Ports:
//   clk, rst, ce            clock, sync active-high reset, clock enable
//   i_vld / i_rdy           input handshake (i_rdy high only in IDLE)
//   i_sign/exp/sig/flags    unpacked operand
//   o_vld / o_rdy           output handshake (o_vld high only in DONE)
//   o_sign/exp/sig/flags    normalised result
//   o_zero                  significand was all zero (finite operand)
//   o_lzc                   number of digit shifts applied
module dfp96_norm_seq #(
    parameter int unsigned DIGITS  = 25,
    parameter int unsigned EXP_WID = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  i_vld,
    output logic                  i_rdy,
    input  logic                  i_sign,
    input  logic [EXP_WID-1:0]    i_exp,
    input  logic [4*DIGITS-1:0]   i_sig,
    input  logic                  i_inf,
    input  logic                  i_nan,
    input  logic                  i_qnan,
    input  logic                  i_snan,
    output logic                  o_vld,
    input  logic                  o_rdy,
    output logic                  o_sign,
    output logic [EXP_WID-1:0]    o_exp,
    output logic [4*DIGITS-1:0]   o_sig,
    output logic                  o_inf,
    output logic                  o_nan,
    output logic                  o_qnan,
    output logic                  o_snan,
    output logic                  o_zero,
    output logic [4:0]            o_lzc
);

    localparam int unsigned SigW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e               state_q, state_d;
    logic                 sign_q, sign_d;
    logic [EXP_WID-1:0]   exp_q, exp_d;
    logic [SigW-1:0]      sig_q, sig_d;
    logic                 inf_q, inf_d;
    logic                 nan_q, nan_d;
    logic                 qnan_q, qnan_d;
    logic                 snan_q, snan_d;
    logic                 zero_q, zero_d;
    logic [4:0]           lzc_q, lzc_d;
    logic                 stop;

    // Shifting is finished once any terminating condition holds on the current operand.
    assign stop = inf_q | nan_q | (sig_q == '0) | (sig_q[SigW-1 -: 4] != 4'h0) |
                  (exp_q == '0);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        qnan_d  = qnan_q;
        snan_d  = snan_q;
        zero_d  = zero_q;
        lzc_d   = lzc_q;
        unique case (state_q)
            StIdle: begin
                if (i_vld) begin
                    sign_d  = i_sign;
                    exp_d   = i_exp;
                    sig_d   = i_sig;
                    inf_d   = i_inf;
                    nan_d   = i_nan;
                    qnan_d  = i_qnan;
                    snan_d  = i_snan;
                    // Zero-ness is shift-invariant, so decide it once at capture.
                    zero_d  = (i_sig == '0) & ~(i_inf | i_nan);
                    lzc_d   = 5'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (stop) begin
                    state_d = StDone;
                end else begin
                    sig_d = {sig_q[SigW-5:0], 4'h0};
                    exp_d = exp_q - {{(EXP_WID-1){1'b0}}, 1'b1};
                    lzc_d = lzc_q + 5'd1;
                end
            end
            StDone: begin
                if (o_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            sig_q   <= '0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            qnan_q  <= 1'b0;
            snan_q  <= 1'b0;
            zero_q  <= 1'b0;
            lzc_q   <= 5'd0;
        end else if (ce) begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            qnan_q  <= qnan_d;
            snan_q  <= snan_d;
            zero_q  <= zero_d;
            lzc_q   <= lzc_d;
        end
    end

    assign i_rdy  = (state_q == StIdle);
    assign o_vld  = (state_q == StDone);
    assign o_sign = sign_q;
    assign o_exp  = exp_q;
    assign o_sig  = sig_q;
    assign o_inf  = inf_q;
    assign o_nan  = nan_q;
    assign o_qnan = qnan_q;
    assign o_snan = snan_q;
    assign o_zero = zero_q;
    assign o_lzc  = lzc_q;

endmodule
